// File: rtl/pc_sequencer_if.sv
// Control-side bundle for pc_sequencer: mode/operand inputs from the control unit,
// branch comparator and register file, plus the PC, EPC and RAS status returned.
interface pc_sequencer_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned IMM_W     = 16,
    parameter int unsigned JUMP_W    = 26,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CntW = $clog2(RAS_DEPTH) + 1;

    logic              stall;
    logic [2:0]        pcsrc;
    logic              brtrue;
    logic [IMM_W-1:0]  imm;
    logic [JUMP_W-1:0] jump;
    logic [XLEN-1:0]   rso;
    logic [XLEN-1:0]   syscall_addr;

    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   epc;
    logic [CntW-1:0]   ras_count;
    logic              ras_full;
    logic              ras_empty;
    logic              ras_ovf;
    logic              ras_unf;
    logic              misalign;

    // Control unit / datapath side
    modport master (
        output stall, pcsrc, brtrue, imm, jump, rso, syscall_addr,
        input  pc, epc, ras_count, ras_full, ras_empty, ras_ovf, ras_unf, misalign
    );

    // Sequencer side
    modport slave (
        input  stall, pcsrc, brtrue, imm, jump, rso, syscall_addr,
        output pc, epc, ras_count, ras_full, ras_empty, ras_ovf, ras_unf, misalign
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next PC from sequential/branch, direct jump,
// register jump, syscall vector, call/return via a circular return-address stack,
// and exception return through the saved EPC. All state updates take one cycle.
module pc_sequencer #(
    parameter int unsigned    XLEN         = 32,
    parameter int unsigned    IMM_W        = 16,
    parameter int unsigned    JUMP_W       = 26,
    parameter int unsigned    RAS_DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input logic           clk,
    input logic           rst,
    pc_sequencer_if.slave bus
);
    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    // Low bits replaced by a direct jump; the upper bits come from p4.
    localparam logic [XLEN-1:0] JumpLowMask = {XLEN{1'b1}} >> (XLEN - JUMP_W - 2);

    typedef enum logic [2:0] {
        SrcSeq  = 3'b000,
        SrcJump = 3'b001,
        SrcJr   = 3'b010,
        SrcSys  = 3'b011,
        SrcCall = 3'b100,
        SrcRet  = 3'b101,
        SrcEret = 3'b110,
        SrcRsvd = 3'b111
    } pcsrc_e;

    pcsrc_e mode;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            mis_q, mis_d;

    // Stack storage; contents are don't-care after reset, so no reset is applied.
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic            push_en;

    logic [XLEN-1:0] p4;
    logic [XLEN-1:0] bt;
    logic [XLEN-1:0] jump_tgt;
    logic [XLEN-1:0] rso_tgt;
    logic [XLEN-1:0] sys_tgt;
    logic [PtrW-1:0] top_idx;
    logic            ras_full;
    logic            ras_empty;

    assign mode = pcsrc_e'(bus.pcsrc);

    // Candidate targets, all modulo 2^XLEN
    assign p4       = pc_q + XLEN'(4);
    assign bt       = p4 + XLEN'($signed({bus.imm, 2'b00}));
    assign jump_tgt = (p4 & ~JumpLowMask) | XLEN'({bus.jump, 2'b00});
    assign rso_tgt  = {bus.rso[XLEN-1:2], 2'b00};
    assign sys_tgt  = {bus.syscall_addr[XLEN-1:2], 2'b00};

    // ptr_q points at the next free slot, so the top of stack sits just below it.
    // When full, the next free slot is also the oldest entry, which a push overwrites.
    assign top_idx   = ptr_q - PtrW'(1);
    assign ras_full  = (count_q == CntW'(RAS_DEPTH));
    assign ras_empty = (count_q == '0);

    // Next-state selection; stall holds architectural state and clears the pulses
    always_comb begin
        pc_d    = pc_q;
        epc_d   = epc_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = 1'b0;
        mis_d   = 1'b0;
        push_en = 1'b0;
        if (!bus.stall) begin
            unique case (mode)
                SrcSeq: begin
                    pc_d = bus.brtrue ? bt : p4;
                end
                SrcJump: begin
                    pc_d = jump_tgt;
                end
                SrcJr: begin
                    pc_d  = rso_tgt;
                    mis_d = |bus.rso[1:0];
                end
                SrcSys: begin
                    pc_d  = sys_tgt;
                    epc_d = pc_q;
                    mis_d = |bus.syscall_addr[1:0];
                end
                SrcCall: begin
                    pc_d    = jump_tgt;
                    push_en = 1'b1;
                    ptr_d   = ptr_q + PtrW'(1);
                    if (ras_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CntW'(1);
                    end
                end
                SrcRet: begin
                    if (ras_empty) begin
                        pc_d  = rso_tgt;
                        unf_d = 1'b1;
                    end else begin
                        pc_d    = ras_q[top_idx];
                        ptr_d   = top_idx;
                        count_d = count_q - CntW'(1);
                    end
                end
                SrcEret: begin
                    pc_d = epc_q + XLEN'(4);
                end
                default: begin
                    pc_d = p4;
                end
            endcase
        end
    end

    // Architectural state and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            mis_q   <= mis_d;
        end
    end

    // Return-address write on call
    always_ff @(posedge clk) begin
        if (push_en) begin
            ras_q[ptr_q] <= p4;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.epc       = epc_q;
    assign bus.ras_count = count_q;
    assign bus.ras_full  = ras_full;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_ovf   = ovf_q;
    assign bus.ras_unf   = unf_q;
    assign bus.misalign  = mis_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver applies one instruction per cycle and
// queues the expected post-edge state from a queue-based reference model; a monitor
// pops and compares after every rising edge.
module tb_pc_sequencer;
    localparam int RAS_DEPTH = 4;

    logic clk;
    logic rst;

    pc_sequencer_if #(
        .XLEN      (32),
        .IMM_W     (16),
        .JUMP_W    (26),
        .RAS_DEPTH (RAS_DEPTH)
    ) bus ();

    pc_sequencer #(
        .XLEN         (32),
        .IMM_W        (16),
        .JUMP_W       (26),
        .RAS_DEPTH    (RAS_DEPTH),
        .RESET_VECTOR (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        int          count;
        logic        ovf;
        logic        unf;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_ovf;
    logic [31:0] ras[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = 32'h0;
        m_epc = 32'h0;
        m_ovf = 1'b0;
        ras.delete();
    endtask

    // One instruction: drive at the falling edge, predict the state after the next rise
    task automatic step(input logic st, input logic [2:0] src, input logic br,
                        input logic [15:0] im, input logic [25:0] jp,
                        input logic [31:0] r, input logic [31:0] sa);
        exp_t        e;
        logic [31:0] p4, nxt, off, jt;
        logic        unf, mis;
        @(negedge clk);
        bus.stall        = st;
        bus.pcsrc        = src;
        bus.brtrue       = br;
        bus.imm          = im;
        bus.jump         = jp;
        bus.rso          = r;
        bus.syscall_addr = sa;
        p4  = m_pc + 32'd4;
        off = 32'($signed(im)) * 4;
        jt  = (p4 & 32'hF000_0000) | ({6'd0, jp} * 4);
        nxt = m_pc;
        unf = 1'b0;
        mis = 1'b0;
        if (!st) begin
            case (src)
                3'd0: nxt = br ? p4 + off : p4;
                3'd1: nxt = jt;
                3'd2: begin
                    nxt = r & ~32'd3;
                    mis = (r % 4) != 0;
                end
                3'd3: begin
                    nxt   = sa & ~32'd3;
                    mis   = (sa % 4) != 0;
                    m_epc = m_pc;
                end
                3'd4: begin
                    nxt = jt;
                    if (ras.size() == RAS_DEPTH) begin
                        void'(ras.pop_front());
                        m_ovf = 1'b1;
                    end
                    ras.push_back(p4);
                end
                3'd5: begin
                    if (ras.size() != 0) begin
                        nxt = ras.pop_back();
                    end else begin
                        nxt = r & ~32'd3;
                        unf = 1'b1;
                    end
                end
                3'd6: nxt = m_epc + 32'd4;
                default: nxt = p4;
            endcase
        end
        m_pc    = nxt;
        e.pc    = m_pc;
        e.epc   = m_epc;
        e.count = ras.size();
        e.ovf   = m_ovf;
        e.unf   = unf;
        e.mis   = mis;
        sb.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"},    bus.pc, 32'h0);
        check({tag, "_epc"},   bus.epc, 32'h0);
        check({tag, "_count"}, 32'(bus.ras_count), 32'd0);
        check({tag, "_empty"}, 32'(bus.ras_empty), 32'd1);
        check({tag, "_full"},  32'(bus.ras_full), 32'd0);
        check({tag, "_ovf"},   32'(bus.ras_ovf), 32'd0);
        check({tag, "_unf"},   32'(bus.ras_unf), 32'd0);
        check({tag, "_mis"},   32'(bus.misalign), 32'd0);
    endtask

    // Monitor: compare DUT state against the oldest queued prediction after each rise
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pc",        bus.pc, e.pc);
                check("epc",       bus.epc, e.epc);
                check("ras_count", 32'(bus.ras_count), 32'(e.count));
                check("ras_full",  32'(bus.ras_full), 32'(e.count == RAS_DEPTH));
                check("ras_empty", 32'(bus.ras_empty), 32'(e.count == 0));
                check("ras_ovf",   32'(bus.ras_ovf), 32'(e.ovf));
                check("ras_unf",   32'(bus.ras_unf), 32'(e.unf));
                check("misalign",  32'(bus.misalign), 32'(e.mis));
            end
        end
    end

    initial begin
        logic [31:0] r;
        bus.stall        = 1'b1;
        bus.pcsrc        = 3'd0;
        bus.brtrue       = 1'b0;
        bus.imm          = '0;
        bus.jump         = '0;
        bus.rso          = '0;
        bus.syscall_addr = '0;
        rst              = 1'b1;
        model_reset();
        #1 rst = 1'b0;
        #2 check_reset_state("reset");
        @(negedge clk);
        rst = 1'b1;

        // Sequential then taken branch backwards
        repeat (3) step(0, 3'd0, 0, 16'h0, 26'h0, 32'h0, 32'h0);
        step(0, 3'd0, 1, 16'hFFFE, 26'h0, 32'h0, 32'h0);
        // Direct jump keeps p4 upper bits; PC wrap
        step(0, 3'd2, 1, 16'h0, 26'h0, 32'h1000_0010, 32'h0);
        step(0, 3'd1, 1, 16'h0, 26'h40, 32'h0, 32'h0);
        step(0, 3'd2, 0, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'h0);
        step(0, 3'd0, 0, 16'h0, 26'h0, 32'h0, 32'h0);
        // Five calls into a four-deep stack, then drain and underflow
        for (int i = 1; i <= 5; i++) begin
            step(0, 3'd2, 0, 16'h0, 26'h0, 32'(i) * 32'h100, 32'h0);
            step(0, 3'd4, 1, 16'h0, 26'h10, 32'h0, 32'h0);
        end
        repeat (4) step(0, 3'd5, 1, 16'h0, 26'h0, 32'h0, 32'h0);
        step(0, 3'd5, 0, 16'h0, 26'h0, 32'h80, 32'h0);
        step(0, 3'd0, 0, 16'h0, 26'h0, 32'h0, 32'h0);
        // Syscall saves PC, eret resumes after it
        step(0, 3'd2, 0, 16'h0, 26'h0, 32'h40, 32'h0);
        step(0, 3'd3, 0, 16'h0, 26'h0, 32'h0, 32'h8000_0000);
        step(0, 3'd6, 1, 16'h0, 26'h0, 32'h0, 32'h0);
        // Misaligned register jump, then a stalled jump
        step(0, 3'd2, 0, 16'h0, 26'h0, 32'h123, 32'h0);
        step(1, 3'd1, 0, 16'h0, 26'h3F, 32'h0, 32'h0);
        step(0, 3'd7, 1, 16'h0, 26'h0, 32'h0, 32'h0);
        // Push once, then reset between edges
        step(0, 3'd4, 0, 16'h0, 26'h5, 32'h0, 32'h0);
        @(posedge clk);
        #2;
        bus.stall = 1'b1;
        rst       = 1'b0;
        #1 check_reset_state("async_reset");
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Randomized instruction mix
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            if ($urandom_range(0, 1) == 0) r[1:0] = 2'b00;
            step(($urandom_range(0, 9) == 0), 3'($urandom_range(0, 7)), 1'($urandom),
                 16'($urandom), 26'($urandom), r, $urandom);
        end

        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program-counter unit for the single-cycle datapath.
- Selects the next PC from:
  - sequential/branch
  - direct jump
  - register jump
  - syscall vector
  - call/return through an internal return-address stack (RAS)
  - exception return through a saved EPC
- Adds a stall input, RAS status flags and an alignment check.
- Feeds instruction memory. Driven by the control unit (pcsrc), the branch comparator (brtrue) and the register file (rso).

Parameters:
- XLEN, 32, datapath/PC width in bits.
- IMM_W, 16, branch immediate width (signed word offset).
- JUMP_W, 26, direct-jump index width; JUMP_W+2 <= XLEN.
- RAS_DEPTH, 4, return-address stack entries; power of 2, >= 2.
- RESET_VECTOR, 0, PC value after reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- stall  in  1  hold all state this cycle
- pcsrc  in  3  next-PC mode select
- brtrue  in  1  branch taken (used only in mode 000)
- imm  in  IMM_W  signed branch word offset
- jump  in  JUMP_W  direct-jump word index
- rso  in  XLEN  register operand for jr / RAS fallback
- syscall_addr  in  XLEN  syscall handler address
- pc  out  XLEN  current PC (registered)
- epc  out  XLEN  saved PC of last syscall (registered)
- ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries
- ras_full  out  1  ras_count == RAS_DEPTH (combinational from count)
- ras_empty  out  1  ras_count == 0
- ras_ovf  out  1  sticky: push occurred while full
- ras_unf  out  1  one-cycle pulse: pop attempted while empty
- misalign  out  1  one-cycle pulse: rso/syscall target had bits[1:0] != 0

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_VECTOR, epc=0, ras_count=0, ras_ovf=0, ras_unf=0, misalign=0, RAS pointer=0.
  - RAS entry contents are don't-care.
- Derived values:
  - p4 = pc+4, modulo 2^XLEN; wrap from all-ones-minus-3 to 0 is legal.
  - bt = p4 + (sext(imm) << 2), modulo 2^XLEN.
- Next PC by pcsrc:
  - 000: brtrue ? bt : p4.
  - 001: {p4[XLEN-1:JUMP_W+2], jump, 2'b00}.
  - 010: {rso[XLEN-1:2], 2'b00}. misalign pulses if rso[1:0] != 0.
  - 011 syscall: {syscall_addr[XLEN-1:2], 2'b00}. epc <= pc. misalign rule as for 010.
  - 100 call: same target as 001. Push p4 onto the RAS.
  - 101 return:
    - RAS not empty: target = top entry, then pop.
    - RAS empty: target = {rso[XLEN-1:2], 2'b00}, ras_unf pulses, count stays 0.
  - 110 eret: epc+4.
  - 111 reserved: p4, no side effects.
- RAS is circular, with pointer wrap modulo RAS_DEPTH:
  - Push when full overwrites the oldest entry. Count stays RAS_DEPTH. ras_ovf sets and stays set until reset.
  - Push and pop never occur in the same cycle, because the modes are exclusive.
- Timing:
  - All updates occur on the rising clk edge with rst=1. Latency is one cycle.
  - ras_unf and misalign are registered: they assert during the cycle after the offending edge, for one cycle.
- stall=1:
  - pc, epc, RAS, ras_count and ras_ovf hold.
  - ras_unf and misalign clear to 0.
  - Mode inputs are ignored.
- brtrue is ignored in every mode other than 000.
- Reset asserted mid-operation takes effect immediately, regardless of clk or stall.

Test Plan:
1. Reset, then 3 clocks of mode 000 with brtrue=0 -> pc = 0, 4, 8, 12. Then brtrue=1, imm=-2 at pc=12 -> pc=8.
2. pc=0x1000_0010, mode 001, jump=0x0000040 -> pc=0x1000_0100. With pc=0xFFFF_FFFC, mode 000 -> pc=0 (wrap).
3. RAS_DEPTH=4:
   - 5 calls from pcs 0x100, 0x200, 0x300, 0x400, 0x500 -> ras_full=1 and ras_ovf=1 after the 5th.
   - 4 returns -> pc = 0x504, 0x404, 0x304, 0x204, then ras_empty=1.
   - 5th return with rso=0x80 -> pc=0x80, ras_unf pulses once.
4. At pc=0x40, mode 011 with syscall_addr=0x8000_0000 -> pc=0x8000_0000, epc=0x40. Then mode 110 -> pc=0x44.
5. Mode 010 with rso=0x123 -> pc=0x120, misalign=1 for one cycle. stall=1 with mode 001 -> pc, epc and ras_count unchanged.
6. Assert rst mid-cycle after a push (ras_count=1) -> pc=RESET_VECTOR, ras_count=0 and ras_ovf=0 immediately, without waiting for a clk edge.
